// File: rtl/decode_sched_pkg.sv
// Shared types and helpers for the time-shared one-hot decoder scheduler.
// Combinational only; no latency or flow control.
package decode_sched_pkg;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_CODE_W = 3;
  localparam int DEF_HOLD   = 2;
  localparam int MAX_CODE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    ACK   = 2'd2
  } state_t;

  // Callers size-cast the result down to 2**CODE_W bits.
  function automatic logic [2**MAX_CODE_W-1:0] onehot(input logic [MAX_CODE_W-1:0] c);
    onehot    = '0;
    onehot[c] = 1'b1;
  endfunction

endpackage

// File: rtl/decode_sched_rr_pick.sv
// Round-robin picker: first set req after ptr, wrapping modulo NREQ.
// Combinational, zero latency; no backpressure.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Scan farthest-to-nearest so the nearest candidate after ptr wins.
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) idx = IDX_W'((int'(ptr) + k) % NREQ);
    end
  end

endmodule

// File: rtl/decode_sched.sv
// Grants one requester round-robin, drives its decoded code for HOLD cycles, then acks.
// Latency: dec_valid the cycle after grant, ack HOLD cycles later; ena low only blocks new grants.
module decode_sched
  import decode_sched_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int CODE_W = DEF_CODE_W,
  parameter int HOLD   = DEF_HOLD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*CODE_W-1:0]     code,
  output logic [NREQ-1:0]            ack,
  output logic [2**CODE_W-1:0]       dec_out,
  output logic                       dec_valid,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int DEC_W = 2**CODE_W;
  localparam int CNT_W = $clog2(HOLD + 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [IDX_W-1:0]   gid_d;
  logic [DEC_W-1:0]   dec_d;
  logic               vld_d;
  logic [NREQ-1:0]    ack_d;
  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= IDX_W'(NREQ - 1);
      cnt_q     <= '0;
      code_q    <= '0;
      grant_id  <= '0;
      dec_out   <= '0;
      dec_valid <= 1'b0;
      ack       <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      grant_id  <= gid_d;
      dec_out   <= dec_d;
      dec_valid <= vld_d;
      ack       <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    gid_d   = grant_id;
    dec_d   = dec_out;
    vld_d   = dec_valid;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (ena && pick_any) begin
          state_d = DRIVE;
          gid_d   = pick_idx;
          code_d  = code[int'(pick_idx) * CODE_W +: CODE_W];
          dec_d   = DEC_W'(onehot(MAX_CODE_W'(code_d)));
          vld_d   = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end
      DRIVE: begin
        // cnt_q counts dec_valid cycles already presented, starting at 1.
        if (cnt_q == CNT_W'(HOLD)) begin
          state_d         = ACK;
          dec_d           = '0;
          vld_d           = 1'b0;
          ack_d[grant_id] = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
        ptr_d   = grant_id;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_decode_sched.sv
// Directed and randomized transactions checked against a transaction-level round-robin model.
module tb_decode_sched;

  localparam int NREQ   = 4;
  localparam int CODE_W = 3;
  localparam int HOLD   = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   ena;
  logic [NREQ-1:0]        req;
  logic [NREQ*CODE_W-1:0] code;
  logic [NREQ-1:0]        ack;
  logic [2**CODE_W-1:0]   dec_out;
  logic                   dec_valid;
  logic [$clog2(NREQ)-1:0] grant_id;
  logic                   busy;

  logic [CODE_W-1:0] codes [NREQ];
  int total = 0;
  int bad   = 0;
  int ref_ptr;

  always #5 clk = ~clk;

  always_comb begin
    code = '0;
    for (int i = 0; i < NREQ; i++) code[i*CODE_W +: CODE_W] = codes[i];
  end

  decode_sched #(.NREQ(NREQ), .CODE_W(CODE_W), .HOLD(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .req       (req),
    .code      (code),
    .ack       (ack),
    .dec_out   (dec_out),
    .dec_valid (dec_valid),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // Reference: first requester strictly after the last served one, cyclically.
  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // mode 1: withdraw req and change code mid-transaction; mode 2: drop ena mid-transaction.
  task automatic run_txn(input int id, input int mode, input bit drop);
    int cd;
    cd = int'(codes[id]);
    tick();
    for (int h = 0; h < HOLD; h++) begin
      check("drive_grant_id", 32'(grant_id), id);
      check("drive_valid", 32'(dec_valid), 1);
      check("drive_dec_out", 32'(dec_out), 1 << cd);
      check("drive_busy", 32'(busy), 1);
      check("drive_ack_quiet", 32'(ack), 0);
      if (h == 0 && mode == 1) begin
        req[id]   = 1'b0;
        codes[id] = codes[id] + 1'b1;
      end
      if (h == 0 && mode == 2) ena = 1'b0;
      tick();
    end
    check("ack_pulse", 32'(ack), 1 << id);
    check("ack_valid_low", 32'(dec_valid), 0);
    check("ack_dec_zero", 32'(dec_out), 0);
    check("ack_busy", 32'(busy), 1);
    if (drop) req[id] = 1'b0;
    ref_ptr = id;
    tick();
    check("idle_busy", 32'(busy), 0);
    check("idle_ack", 32'(ack), 0);
    check("idle_grant_hold", 32'(grant_id), id);
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    req = '1;
    for (int i = 0; i < NREQ; i++) codes[i] = CODE_W'($urandom_range(0, 2**CODE_W - 1));
    ref_ptr = NREQ - 1;
    #1;
    check("rst_dec_out", 32'(dec_out), 0);
    check("rst_valid", 32'(dec_valid), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    tick();
    tick();
    rst = 1'b0;

    // All requesting continuously: strict rotation from requester 0.
    for (int k = 0; k < NREQ + 1; k++) begin
      codes[pick(req, ref_ptr)] = CODE_W'($urandom_range(0, 2**CODE_W - 1));
      run_txn(pick(req, ref_ptr), 0, 1'b0);
      check("rr_order", 32'(grant_id), k % NREQ);
    end
    req = '0;

    // Single request, code 5 -> 8'h20.
    req = 4'b0100;
    codes[2] = 3'd5;
    run_txn(pick(req, ref_ptr), 0, 1'b1);
    check("single_dec_pattern", 32'(dut.dec_out), 0);

    // Single requester back-to-back.
    req = 4'b0001;
    run_txn(pick(req, ref_ptr), 0, 1'b0);
    run_txn(pick(req, ref_ptr), 0, 1'b1);

    // Withdrawal during DRIVE with code change.
    req = 4'b0010;
    codes[1] = CODE_W'($urandom_range(0, 2**CODE_W - 1));
    run_txn(pick(req, ref_ptr), 1, 1'b0);

    // Enable gating.
    ena = 1'b0;
    req = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("gated_busy", 32'(busy), 0);
      check("gated_valid", 32'(dec_valid), 0);
    end
    ena = 1'b1;
    run_txn(pick(req, ref_ptr), 2, 1'b0);
    tick();
    tick();
    check("ena_low_no_regrant", 32'(busy), 0);
    ena = 1'b1;
    req = '0;
    tick();

    // Reset in the middle of DRIVE for requester 3.
    req = 4'b1000;
    codes[3] = CODE_W'($urandom_range(0, 2**CODE_W - 1));
    tick();
    check("abort_grant_id", 32'(grant_id), 3);
    check("abort_driving", 32'(dec_valid), 1);
    rst = 1'b1;
    #1;
    check("abort_valid_drop", 32'(dec_valid), 0);
    check("abort_dec_drop", 32'(dec_out), 0);
    check("abort_busy_drop", 32'(busy), 0);
    tick();
    check("abort_no_ack", 32'(ack), 0);
    rst = 1'b0;
    ref_ptr = NREQ - 1;
    run_txn(pick(req, ref_ptr), 0, 1'b1);

    // Randomized traffic obeying the req/ack handshake.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          req[i]   = 1'b1;
          codes[i] = CODE_W'($urandom_range(0, 2**CODE_W - 1));
        end
      end
      if (req == '0) begin
        req[t % NREQ]   = 1'b1;
        codes[t % NREQ] = CODE_W'($urandom_range(0, 2**CODE_W - 1));
      end
      run_txn(pick(req, ref_ptr), 0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
